// File: rtl/uart_rx_if.sv
// Receive-side bus of the UART receiver: serial line in, byte handshake out.
interface uart_rx_if;
  logic       rx_pin;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_data_ready;
  logic       frame_err;

  // master: the receiver; slave: the byte consumer / line driver
  modport master (
    input  rx_pin,
    input  rx_data_ready,
    output rx_data,
    output rx_data_valid,
    output frame_err
  );

  modport slave (
    output rx_pin,
    output rx_data_ready,
    input  rx_data,
    input  rx_data_valid,
    input  frame_err
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a valid/ready byte handshake.
//
// state      | meaning
// S_IDLE     | waiting for a falling edge on the synchronized line
// S_START    | inside the start bit, mid-bit glitch check
// S_REC_BYTE | sampling eight data bits, LSB first
// S_STOP     | sampling the stop bit at its midpoint
// S_DATA     | byte presented, waiting for the consumer
module uart_rx #(
  parameter int CLK_FRE   = 50,
  parameter int BAUD_RATE = 115200
) (
  input  logic      clk,
  input  logic      rst_n,
  uart_rx_if.master bus
);

  localparam int          CYCLE    = CLK_FRE * 1000000 / BAUD_RATE;
  localparam logic [15:0] CNT_HALF = 16'(CYCLE / 2);
  localparam logic [15:0] CNT_LAST = 16'(CYCLE - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_REC_BYTE = 3'd2,
    S_STOP     = 3'd3,
    S_DATA     = 3'd4
  } state_t;

  state_t      state, next_state;
  logic        rx_d0, rx_d1;
  logic        rx_sync;
  logic        rx_negedge;
  logic [15:0] cycle_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  rx_bits;
  logic [7:0]  rx_data_q;
  logic        valid_q;
  logic        frame_err_q;

  logic        at_half;
  logic        at_last;
  logic        load_byte;
  logic        err_set;
  logic        handshake;

  assign rx_sync    = rx_d1;
  // Edge detector sees the first flop as "new" so an edge is caught one clock early.
  assign rx_negedge = rx_d1 & ~rx_d0;
  assign at_half    = (cycle_cnt == CNT_HALF);
  assign at_last    = (cycle_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_d0 <= 1'b1;
      rx_d1 <= 1'b1;
    end else begin
      rx_d0 <= bus.rx_pin;
      rx_d1 <= rx_d0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:     if (rx_negedge) next_state = S_START;
      S_START: begin
        if (at_half && rx_sync) next_state = S_IDLE;
        else if (at_last)       next_state = S_REC_BYTE;
      end
      S_REC_BYTE: if (at_last && bit_cnt == 3'd7) next_state = S_STOP;
      S_STOP:     if (at_half) next_state = rx_sync ? S_DATA : S_IDLE;
      S_DATA:     if (valid_q && bus.rx_data_ready) next_state = S_IDLE;
      default:    next_state = S_IDLE;
    endcase
  end

  always_comb begin
    load_byte = 1'b0;
    err_set   = 1'b0;
    handshake = 1'b0;
    case (state)
      S_STOP: begin
        load_byte = at_half &  rx_sync;
        err_set   = at_half & ~rx_sync;
      end
      S_DATA:  handshake = valid_q & bus.rx_data_ready;
      default: ;
    endcase
  end

  // Counter restarts on every state change and at each data-bit boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= 16'd0;
    end else if (next_state != state) begin
      cycle_cnt <= 16'd0;
    end else if (state == S_REC_BYTE && at_last) begin
      cycle_cnt <= 16'd0;
    end else if (state == S_START || state == S_REC_BYTE || state == S_STOP) begin
      cycle_cnt <= cycle_cnt + 16'd1;
    end else begin
      cycle_cnt <= 16'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= 3'd0;
      rx_bits <= 8'h00;
    end else if (state == S_REC_BYTE) begin
      if (at_half) rx_bits[bit_cnt] <= rx_sync;
      if (at_last) bit_cnt <= bit_cnt + 3'd1;
    end else begin
      bit_cnt <= 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_q   <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= err_set;
      if (load_byte) begin
        rx_data_q <= rx_bits;
        valid_q   <= 1'b1;
      end else if (handshake) begin
        valid_q   <= 1'b0;
      end
    end
  end

  assign bus.rx_data       = rx_data_q;
  assign bus.rx_data_valid = valid_q;
  assign bus.frame_err     = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at default parameters (434 clocks per bit).
module tb_uart_rx;

  localparam int CYCLE = 434;

  logic clk;
  logic rst_n;
  uart_rx_if bus_if ();

  uart_rx dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.master)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int checks;
  int failures;

  int valid_cycles;
  int err_cycles;
  logic [7:0] cap_q[$];
  logic prev_valid;

  initial begin
    valid_cycles = 0;
    err_cycles   = 0;
    prev_valid   = 1'b0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_if.rx_data_valid) valid_cycles = valid_cycles + 1;
      if (bus_if.rx_data_valid && !prev_valid) cap_q.push_back(bus_if.rx_data);
      if (bus_if.frame_err) err_cycles = err_cycles + 1;
      prev_valid = bus_if.rx_data_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    checks = checks + 1;
    if (actual !== expected) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Caller must be at a falling clock edge; returns at one too, line idle.
  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    bus_if.rx_pin = 1'b0;
    repeat (CYCLE) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus_if.rx_pin = d[i];
      repeat (CYCLE) @(negedge clk);
    end
    bus_if.rx_pin = stop_bit;
    repeat (CYCLE) @(negedge clk);
    bus_if.rx_pin = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    int         exp_valid_cycles;
    int         exp_err_cycles;
    logic [7:0] exp_rx_data;
  } vec_t;

  vec_t vecs[5];

  int v0, e0, q0, hold_bad, budget;

  initial begin
    checks   = 0;
    failures = 0;
    vecs[0] = '{8'h55, 1'b1, 1, 0, 8'h55};
    vecs[1] = '{8'h3C, 1'b0, 0, 1, 8'h55};
    vecs[2] = '{8'hC6, 1'b1, 1, 0, 8'hC6};
    vecs[3] = '{8'h00, 1'b1, 1, 0, 8'h00};
    vecs[4] = '{8'hFF, 1'b1, 1, 0, 8'hFF};

    bus_if.rx_pin        = 1'b1;
    bus_if.rx_data_ready = 1'b1;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_rx_data", int'(bus_if.rx_data), 8'h00);
    check("reset_valid", int'(bus_if.rx_data_valid), 0);
    check("reset_frame_err", int'(bus_if.frame_err), 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Single frames with ready held high: valid and frame_err are one-clock pulses.
    for (int k = 0; k < 5; k++) begin
      v0 = valid_cycles;
      e0 = err_cycles;
      send_byte(vecs[k].data, vecs[k].stop_bit);
      repeat (20) @(negedge clk);
      check($sformatf("vec%0d_valid_cycles", k), valid_cycles - v0, vecs[k].exp_valid_cycles);
      check($sformatf("vec%0d_err_cycles", k), err_cycles - e0, vecs[k].exp_err_cycles);
      check($sformatf("vec%0d_rx_data", k), int'(bus_if.rx_data), int'(vecs[k].exp_rx_data));
    end

    // Back-to-back frames, no idle gap between stop bit and next start bit.
    q0 = cap_q.size();
    v0 = valid_cycles;
    send_byte(8'hA3, 1'b1);
    send_byte(8'h0F, 1'b1);
    repeat (20) @(negedge clk);
    check("b2b_pulses", cap_q.size() - q0, 2);
    check("b2b_valid_cycles", valid_cycles - v0, 2);
    if (cap_q.size() - q0 == 2) begin
      check("b2b_first", int'(cap_q[q0]), 8'hA3);
      check("b2b_second", int'(cap_q[q0 + 1]), 8'h0F);
    end

    // Consumer stalls for 2000 clocks.
    bus_if.rx_data_ready = 1'b0;
    send_byte(8'h81, 1'b1);
    budget = 0;
    while (!bus_if.rx_data_valid && budget < 3 * CYCLE) begin
      @(negedge clk);
      budget++;
    end
    check("hold_valid_seen", int'(bus_if.rx_data_valid), 1);
    hold_bad = 0;
    repeat (2000) begin
      @(negedge clk);
      if (!bus_if.rx_data_valid || bus_if.rx_data !== 8'h81) hold_bad++;
    end
    check("hold_stable_cycles_bad", hold_bad, 0);
    bus_if.rx_data_ready = 1'b1;
    @(negedge clk);
    check("hold_valid_dropped", int'(bus_if.rx_data_valid), 0);
    check("hold_data_kept", int'(bus_if.rx_data), 8'h81);

    // Short low glitch on an idle line.
    v0 = valid_cycles;
    e0 = err_cycles;
    bus_if.rx_pin = 1'b0;
    repeat (100) @(negedge clk);
    bus_if.rx_pin = 1'b1;
    repeat (600) @(negedge clk);
    check("glitch_valid_cycles", valid_cycles - v0, 0);
    check("glitch_err_cycles", err_cycles - e0, 0);
    v0 = valid_cycles;
    send_byte(8'h7E, 1'b1);
    repeat (20) @(negedge clk);
    check("post_glitch_valid_cycles", valid_cycles - v0, 1);
    check("post_glitch_rx_data", int'(bus_if.rx_data), 8'h7E);

    // Reset in the middle of data bit 4 of 0xFF.
    v0 = valid_cycles;
    e0 = err_cycles;
    bus_if.rx_pin = 1'b0;
    repeat (CYCLE) @(negedge clk);
    bus_if.rx_pin = 1'b1;
    repeat (4 * CYCLE + CYCLE / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset_rx_data", int'(bus_if.rx_data), 8'h00);
    check("midreset_valid", int'(bus_if.rx_data_valid), 0);
    check("midreset_frame_err", int'(bus_if.frame_err), 0);
    rst_n = 1'b1;
    repeat (4 * CYCLE) @(negedge clk);
    check("midreset_no_valid", valid_cycles - v0, 0);
    check("midreset_no_err", err_cycles - e0, 0);
    v0 = valid_cycles;
    send_byte(8'h12, 1'b1);
    repeat (20) @(negedge clk);
    check("post_reset_valid_cycles", valid_cycles - v0, 1);
    check("post_reset_rx_data", int'(bus_if.rx_data), 8'h12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
